// File: rtl/filter_mode_if.sv
`default_nettype none
// ============================================================================
// Module      : filter_mode_if
// Description : Bundle for filter_mode_scheduler. Carries the incoming VGA
//               timing, the mode-request controls, and the committed mode
//               with the pixel coordinate and timing outputs.
//               master = timing/control source, slave = scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface filter_mode_if;
  // incoming VGA timing
  logic       iVGA_HS;
  logic       iVGA_VS;
  logic       iVGA_BLANK_N;
  // mode requests
  logic [7:0] sw_mode;
  logic       key_next_n;
  logic       auto_en;
  // scheduler results
  logic [7:0] mode;
  logic       mode_changed;
  logic [9:0] x;
  logic [8:0] y;
  logic       border;
  logic [7:0] frame_count;
  // registered timing, aligned with x/y/border
  logic       hs_d;
  logic       vs_d;
  logic       blank_n_d;

  modport master (
    output iVGA_HS, iVGA_VS, iVGA_BLANK_N, sw_mode, key_next_n, auto_en,
    input  mode, mode_changed, x, y, border, frame_count, hs_d, vs_d, blank_n_d
  );

  modport slave (
    input  iVGA_HS, iVGA_VS, iVGA_BLANK_N, sw_mode, key_next_n, auto_en,
    output mode, mode_changed, x, y, border, frame_count, hs_d, vs_d, blank_n_d
  );
endinterface
`default_nettype wire

// File: rtl/filter_mode_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : filter_mode_scheduler
// Description : Tracks pixel x/y/border from VGA timing, counts frames and
//               schedules the filter mode. Mode requests come from switches,
//               a "next" button and (optionally) an auto-cycle timer; the
//               chosen mode is committed only at frame start.
//               Optional feature macro: FILTER_AUTO_CYCLE_EN (AUTO state and
//               its frame counter).
// Revision    : 1.0 - initial release
// ============================================================================
module filter_mode_scheduler #(
  parameter int WIDTH       = 800,
  parameter int HEIGHT      = 480,
  parameter int NUM_MODES   = 12,
  parameter int AUTO_FRAMES = 120
) (
  input  logic         VGA_CLK,
  input  logic         reset_n,
  filter_mode_if.slave bus
);

  localparam logic [9:0] X_LAST     = 10'(WIDTH - 1);
  localparam logic [8:0] Y_LAST     = 9'(HEIGHT - 1);
  localparam logic [8:0] MODE_LIMIT = 9'(NUM_MODES);
  localparam logic [7:0] MODE_LAST  = 8'(NUM_MODES - 1);

`ifdef FILTER_AUTO_CYCLE_EN
  localparam int                AUTO_W    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);
  typedef enum logic [1:0] {S_FOLLOW = 2'd0, S_STEP = 2'd1, S_AUTO = 2'd2} state_t;
`else
  typedef enum logic [0:0] {S_FOLLOW = 1'b0, S_STEP = 1'b1} state_t;
`endif

  logic       r_hs, r_vs, r_blank, r_vs_prev, r_blank_prev;
  logic [9:0] r_x;
  logic [8:0] r_y;
  logic [7:0] r_frame_count;
  logic [2:0] r_key_sync;
  logic [7:0] r_mode;
  logic       r_mode_changed;
  state_t     r_state, w_state_nx;
  logic [7:0] r_pending, w_pending_nx;
  logic [7:0] r_sw_latch, w_sw_latch_nx;
  logic [7:0] w_commit;
`ifdef FILTER_AUTO_CYCLE_EN
  logic [AUTO_W-1:0] r_auto_cnt, w_auto_cnt_nx;
`endif

  logic       w_frame_start, w_line_end, w_press;
  logic [7:0] w_sw_legal;

  assign w_frame_start = r_vs_prev & ~r_vs;
  assign w_line_end    = r_blank_prev & ~r_blank;
  // key_sync[2] is the previous synchronized level, [1] the current one
  assign w_press       = r_key_sync[2] & ~r_key_sync[1];
  assign w_sw_legal    = ({1'b0, bus.sw_mode} >= MODE_LIMIT) ? 8'd0 : bus.sw_mode;

  function automatic logic [7:0] next_mode(input logic [7:0] m);
    return (m == MODE_LAST) ? 8'd0 : m + 8'd1;
  endfunction

  // Register the VGA timing once, plus one more stage for edge detection
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_hs         <= 1'b0;
      r_vs         <= 1'b0;
      r_blank      <= 1'b0;
      r_vs_prev    <= 1'b0;
      r_blank_prev <= 1'b0;
    end else begin
      r_hs         <= bus.iVGA_HS;
      r_vs         <= bus.iVGA_VS;
      r_blank      <= bus.iVGA_BLANK_N;
      r_vs_prev    <= r_vs;
      r_blank_prev <= r_blank;
    end
  end

  // Pixel coordinates (saturating) and frame counter
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frame_count <= '0;
    end else begin
      if (!r_blank)          r_x <= '0;
      else if (r_x != X_LAST) r_x <= r_x + 10'd1;

      if (!r_vs)                            r_y <= '0;
      else if (w_line_end && r_y != Y_LAST) r_y <= r_y + 9'd1;

      if (w_frame_start) r_frame_count <= r_frame_count + 8'd1;
    end
  end

  // Two-flop synchronizer for the button plus one delay stage for edge detect
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) r_key_sync <= 3'b111;
    else          r_key_sync <= {r_key_sync[1:0], bus.key_next_n};
  end

  // FSM next-state and pending-mode logic
  always_comb begin
    w_state_nx    = r_state;
    w_pending_nx  = r_pending;
    w_sw_latch_nx = r_sw_latch;
    w_commit      = r_pending;
`ifdef FILTER_AUTO_CYCLE_EN
    w_auto_cnt_nx = r_auto_cnt;
`endif
    case (r_state)
      S_FOLLOW: begin
        w_pending_nx = w_sw_legal;
        if (w_press) begin
          w_state_nx    = S_STEP;
          w_sw_latch_nx = bus.sw_mode;
          w_pending_nx  = next_mode(r_pending);
        end
      end
      S_STEP: begin
        if (bus.sw_mode != r_sw_latch) begin
          w_state_nx   = S_FOLLOW;
          w_pending_nx = w_sw_legal;
        end else if (w_press) begin
          w_pending_nx = next_mode(r_pending);
        end
      end
`ifdef FILTER_AUTO_CYCLE_EN
      S_AUTO: begin
        // a press wins over a coinciding auto step; the auto step is
        // committed on the very frame start that triggers it
        if (w_press) begin
          w_pending_nx  = next_mode(r_pending);
          w_auto_cnt_nx = '0;
        end else if (w_frame_start) begin
          if (r_auto_cnt == AUTO_LAST) begin
            w_auto_cnt_nx = '0;
            w_pending_nx  = next_mode(r_pending);
            w_commit      = w_pending_nx;
          end else begin
            w_auto_cnt_nx = r_auto_cnt + AUTO_W'(1);
          end
        end
        if (!bus.auto_en) w_state_nx = S_FOLLOW;
      end
`endif
      default: w_state_nx = S_FOLLOW;
    endcase
`ifdef FILTER_AUTO_CYCLE_EN
    if (bus.auto_en && r_state != S_AUTO) begin
      w_state_nx    = S_AUTO;
      w_pending_nx  = r_pending;
      w_sw_latch_nx = r_sw_latch;
      w_auto_cnt_nx = '0;
    end
`endif
  end

  // FSM state register
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_FOLLOW;
      r_pending  <= '0;
      r_sw_latch <= '0;
`ifdef FILTER_AUTO_CYCLE_EN
      r_auto_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_pending  <= w_pending_nx;
      r_sw_latch <= w_sw_latch_nx;
`ifdef FILTER_AUTO_CYCLE_EN
      r_auto_cnt <= w_auto_cnt_nx;
`endif
    end
  end

  // Commit pending mode at frame start only; pulse when the value changes
  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_mode         <= '0;
      r_mode_changed <= 1'b0;
    end else if (w_frame_start) begin
      r_mode         <= w_commit;
      r_mode_changed <= (w_commit != r_mode);
    end else begin
      r_mode_changed <= 1'b0;
    end
  end

  assign bus.mode         = r_mode;
  assign bus.mode_changed = r_mode_changed;
  assign bus.x            = r_x;
  assign bus.y            = r_y;
  assign bus.border       = r_blank & ((r_x == 10'd0) | (r_x == X_LAST) |
                                       (r_y == 9'd0)  | (r_y == Y_LAST));
  assign bus.frame_count  = r_frame_count;
  assign bus.hs_d         = r_hs;
  assign bus.vs_d         = r_vs;
  assign bus.blank_n_d    = r_blank;

endmodule
`default_nettype wire

// File: doc/filter_mode_scheduler.md
FILTER_MODE_SCHEDULER -- requirements
Module: filter_mode_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 800: active pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 480: active lines per frame.
REQ-003 SHALL have parameter NUM_MODES, default 12: legal filter modes are 0..NUM_MODES-1, and mode 0 is pass-through.
REQ-004 SHALL have parameter AUTO_FRAMES, default 120: frames per auto-cycle step.
REQ-005 SHALL have port VGA_CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports iVGA_HS, iVGA_VS and iVGA_BLANK_N, each input, 1 bit: incoming VGA timing.
REQ-008 SHALL have port sw_mode, input, 8 bits: switch-requested mode.
REQ-009 SHALL have port key_next_n, input, 1 bit: asynchronous, active-low "next mode" button.
REQ-010 SHALL have port auto_en, input, 1 bit: auto-cycle request.
REQ-011 SHALL have port mode, output, 8 bits: committed mode that drives the filter output mux.
REQ-012 SHALL have port mode_changed, output, 1 bit: single-cycle commit pulse.
REQ-013 SHALL have ports x (output, 10 bits) and y (output, 9 bits): coordinates of the active pixel.
REQ-014 SHALL have port border, output, 1 bit: the pixel is on the frame edge, where the 3x3 window is invalid.
REQ-015 SHALL have port frame_count, output, 8 bits: count of frame starts.

Function
REQ-016 SHALL register iVGA_HS, iVGA_VS and iVGA_BLANK_N once, so that x, y and border align one cycle after the input pixel.
REQ-017 SHALL count x from 0 on each cycle with registered BLANK_N=1, and clear x when BLANK_N=0.
REQ-018 SHALL increment y on each registered BLANK_N 1->0 transition, and clear y while registered VS=0.
REQ-019 SHALL saturate x at WIDTH-1 and y at HEIGHT-1, with no wrap.
REQ-020 SHALL assert border only while registered BLANK_N=1 and (x==0, x==WIDTH-1, y==0 or y==HEIGHT-1).
REQ-021 SHALL define a frame start as registered VS 1->0, and increment frame_count on it, wrapping from 255 to 0.
REQ-022 SHALL pass key_next_n through a 2-flop synchronizer, and treat a synchronized 1->0 transition as one press.
REQ-023 SHALL run an FSM with states FOLLOW, STEP and AUTO, and with reset state FOLLOW.
REQ-024 In FOLLOW, pending SHALL equal sw_mode, or 0 if sw_mode>=NUM_MODES.
REQ-025 A press in FOLLOW or STEP SHALL move the FSM to STEP and set pending = (pending+1) mod NUM_MODES.
REQ-026 Multiple presses within one frame SHALL accumulate.
REQ-027 STEP SHALL return to FOLLOW when sw_mode differs from its value latched at STEP entry.
REQ-028 With auto_en=1, any state SHALL go to AUTO, and AUTO SHALL return to FOLLOW when auto_en=0.
REQ-029 In AUTO, pending SHALL advance by 1 mod NUM_MODES on every AUTO_FRAMES-th frame start.
REQ-030 In AUTO, a press SHALL also advance pending and clear the frame counter.
REQ-031 If a press and an auto step occur on the same cycle, the FSM SHALL advance once only, and the press SHALL take priority.
REQ-032 On a frame start, mode SHALL load pending, so mode never changes mid-frame.
REQ-033 mode_changed SHALL be 1 for the single cycle after a commit, and only when the new mode differs from the old one.
REQ-034 A press on the same cycle as a frame start SHALL update pending after the commit, so it takes effect at the next frame.

Reset
REQ-035 reset_n=0 SHALL immediately force mode=0, mode_changed=0, x=0, y=0, border=0, frame_count=0, pending=0, the auto counter to 0, the synchronizers to 1 and the FSM to FOLLOW.
REQ-036 After reset is released mid-frame, mode SHALL stay 0 until the next frame start, and the counters SHALL resynchronize at the next BLANK_N and VS edges.

Configuration
REQ-037 SHALL support macro FILTER_AUTO_CYCLE_EN: when defined, the AUTO state and the auto counter are built in.
REQ-038 When FILTER_AUTO_CYCLE_EN is undefined, the AUTO state and its counter SHALL be absent, auto_en SHALL be ignored, and the FSM SHALL use only FOLLOW and STEP.

Verification
REQ-039 Reset, then sw_mode=5 mid-frame -> mode stays 0 until the VS fall, then becomes 5 with a 1-cycle mode_changed pulse.
REQ-040 sw_mode=200 while mode=3 -> after the next frame start, mode=0 and mode_changed pulses once.
REQ-041 mode=10, then two presses within one frame -> next frame gives mode=0 (wrap), and the FSM is in STEP; changing sw_mode to 4 -> FOLLOW, and next frame gives mode=4.
REQ-042 With FILTER_AUTO_CYCLE_EN, AUTO_FRAMES=2, auto_en=1 and mode=0 -> mode reads 1, 2, 3 at frame starts 2, 4, 6, and frame_count reaches 6; without the macro, mode stays at sw_mode.
REQ-043 One 800x480 frame -> x peaks at 799, y at 479, and border is high for exactly 2556 cycles.
REQ-044 reset_n pulsed low mid-line -> all outputs read 0 that cycle, and mode is unchanged until the next frame start.
